flag_ctrl: RTL and testbench

FLAG_CTRL -- requirements
Module: flag_ctrl

---
 rtl/flag_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_flag_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_ctrl.sv
// ============================================================================
// Module   : flag_ctrl
// Purpose  : Control sequencer for the CPU flag register (C, Z, B).
//            - Normal (IDLE) operation forwards ALU results to the flag
//              register inputs.
//            - CLEAR resets the flag register for one cycle.
//            - A DEPTH-entry LIFO saves and restores the flag context.
//            - Branch-condition queries are evaluated against the current
//              flags and returned one cycle later.
// Ports    :
//   clk, rst_n                      clock, async active-low reset
//   alu_valid, alu_cb               ALU result valid / op writes carry-borrow
//   alu_c, alu_z, alu_b             raw ALU flag results
//   flag_c, flag_z, flag_b          current flag register contents
//   clr_req, push_req, pop_req      clear / save context / restore context
//   cond_req, cond_sel[2:0]         branch-condition query
//   flag_rst, flag_cb_valid,
//   flag_c_in, flag_z_in, flag_b_in flag register controls (combinational)
//   busy                            high while in CLEAR or RESTORE
//   push_ack, pop_ack, cond_ack     registered one-cycle acknowledges
//   cond_true                       condition result, valid with cond_ack
//   stk_cnt                         stack occupancy
//   stk_ovf, stk_unf                sticky overflow / underflow flags
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flag_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic                       alu_cb,
    input  logic                       alu_c,
    input  logic                       alu_z,
    input  logic                       alu_b,
    input  logic                       flag_c,
    input  logic                       flag_z,
    input  logic                       flag_b,
    input  logic                       clr_req,
    input  logic                       push_req,
    input  logic                       pop_req,
    input  logic                       cond_req,
    input  logic [2:0]                 cond_sel,
    output logic                       flag_rst,
    output logic                       flag_cb_valid,
    output logic                       flag_c_in,
    output logic                       flag_z_in,
    output logic                       flag_b_in,
    output logic                       busy,
    output logic                       push_ack,
    output logic                       pop_ack,
    output logic                       cond_ack,
    output logic                       cond_true,
    output logic [$clog2(DEPTH+1)-1:0] stk_cnt,
    output logic                       stk_ovf,
    output logic                       stk_unf
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        RESTORE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Stack entries packed as {C, Z, B}
    logic [2:0] stack [DEPTH];

    logic take_clr;
    logic take_pop;
    logic take_push;
    logic stk_full;
    logic stk_empty;
    logic [2:0] restore_val;

    function automatic logic cond_eval(input logic [2:0] sel,
                                       input logic c,
                                       input logic z,
                                       input logic b);
        logic r;
        case (sel)
            3'd0:    r = 1'b1;
            3'd1:    r = c;
            3'd2:    r = ~c;
            3'd3:    r = z;
            3'd4:    r = ~z;
            3'd5:    r = b;
            3'd6:    r = ~b;
            default: r = c | z;
        endcase
        return r;
    endfunction

    // Request arbitration: only IDLE samples requests, clr > pop > push,
    // losers are simply dropped.
    always_comb begin
        take_clr  = (state == IDLE) && clr_req;
        take_pop  = (state == IDLE) && !clr_req && pop_req;
        take_push = (state == IDLE) && !clr_req && !pop_req && push_req;
        stk_full  = (stk_cnt == FULL_CNT);
        stk_empty = (stk_cnt == '0);
    end

    // stk_cnt was already decremented on entry to RESTORE, so it now
    // addresses the entry being restored.
    assign restore_val = stack[stk_cnt[IW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        flag_rst      = 1'b0;
        flag_cb_valid = 1'b0;
        flag_c_in     = 1'b0;
        flag_z_in     = 1'b0;
        flag_b_in     = 1'b0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                flag_cb_valid = alu_valid & alu_cb;
                flag_c_in     = alu_c;
                flag_b_in     = alu_b;
                // Z is held at its current value when no ALU result exists
                flag_z_in     = alu_valid ? alu_z : flag_z;
                if (take_clr) begin
                    next_state = CLEAR;
                end else if (take_pop && !stk_empty) begin
                    next_state = RESTORE;
                end
            end
            CLEAR: begin
                flag_rst   = 1'b1;
                busy       = 1'b1;
                next_state = IDLE;
            end
            RESTORE: begin
                flag_cb_valid = 1'b1;
                flag_c_in     = restore_val[2];
                flag_z_in     = restore_val[1];
                flag_b_in     = restore_val[0];
                busy          = 1'b1;
                next_state    = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        // The flag register must see no write strobes while reset is held,
        // even though the IDLE path would otherwise forward alu_valid.
        if (!rst_n) begin
            flag_rst      = 1'b0;
            flag_cb_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk_cnt   <= '0;
            stk_ovf   <= 1'b0;
            stk_unf   <= 1'b0;
            push_ack  <= 1'b0;
            pop_ack   <= 1'b0;
            cond_ack  <= 1'b0;
            cond_true <= 1'b0;
        end else begin
            push_ack  <= take_push;
            // For a successful pop this lands in the RESTORE cycle itself
            pop_ack   <= take_pop;
            cond_ack  <= cond_req;
            cond_true <= cond_req ? cond_eval(cond_sel, flag_c, flag_z, flag_b) : 1'b0;
            if (take_clr) begin
                stk_ovf <= 1'b0;
                stk_unf <= 1'b0;
            end
            if (take_pop) begin
                if (stk_empty) begin
                    stk_unf <= 1'b1;
                end else begin
                    stk_cnt <= stk_cnt - CW'(1);
                end
            end
            if (take_push) begin
                if (stk_full) begin
                    stk_ovf <= 1'b1;
                end else begin
                    stk_cnt <= stk_cnt + CW'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stack
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stack[i] <= 3'b000;
            end else if (take_push && !stk_full && (stk_cnt == CW'(i))) begin
                // Pre-update flag values: the ALU write of this cycle is
                // not yet visible in flag_c/z/b.
                stack[i] <= {flag_c, flag_z, flag_b};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_flag_ctrl.sv
// ============================================================================
// Module   : tb_flag_ctrl
// Purpose  : Self-checking bench for flag_ctrl. A behavioural model (queue
//            based stack, phase tracking) predicts every output each cycle;
//            directed sequences add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flag_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int OW    = CW + 12;

    // bit positions in the packed observation vector
    localparam int B_UNF = CW;
    localparam int B_OVF = CW + 1;
    localparam int B_CT  = CW + 2;
    localparam int B_CA  = CW + 3;
    localparam int B_QA  = CW + 4;
    localparam int B_PA  = CW + 5;
    localparam int B_BSY = CW + 6;
    localparam int B_BIN = CW + 7;
    localparam int B_ZIN = CW + 8;
    localparam int B_CIN = CW + 9;
    localparam int B_CBV = CW + 10;
    localparam int B_RST = CW + 11;

    logic clk = 1'b0;
    logic rst_n;
    logic alu_valid, alu_cb, alu_c, alu_z, alu_b;
    logic flag_c, flag_z, flag_b;
    logic clr_req, push_req, pop_req, cond_req;
    logic [2:0] cond_sel;
    logic flag_rst, flag_cb_valid, flag_c_in, flag_z_in, flag_b_in;
    logic busy, push_ack, pop_ack, cond_ack, cond_true;
    logic [CW-1:0] stk_cnt;
    logic stk_ovf, stk_unf;

    flag_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_cb       (alu_cb),
        .alu_c        (alu_c),
        .alu_z        (alu_z),
        .alu_b        (alu_b),
        .flag_c       (flag_c),
        .flag_z       (flag_z),
        .flag_b       (flag_b),
        .clr_req      (clr_req),
        .push_req     (push_req),
        .pop_req      (pop_req),
        .cond_req     (cond_req),
        .cond_sel     (cond_sel),
        .flag_rst     (flag_rst),
        .flag_cb_valid(flag_cb_valid),
        .flag_c_in    (flag_c_in),
        .flag_z_in    (flag_z_in),
        .flag_b_in    (flag_b_in),
        .busy         (busy),
        .push_ack     (push_ack),
        .pop_ack      (pop_ack),
        .cond_ack     (cond_ack),
        .cond_true    (cond_true),
        .stk_cnt      (stk_cnt),
        .stk_ovf      (stk_ovf),
        .stk_unf      (stk_unf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    // ---------------- behavioural model ----------------
    int       m_phase;           // 0 normal, 1 clearing, 2 restoring
    bit [2:0] m_stk[$];          // {C,Z,B}, back of queue = top of stack
    bit [2:0] m_rv;
    bit       m_ovf, m_unf, m_pa, m_qa, m_ca, m_ct;

    function automatic bit cond_ref(input bit [2:0] sel, input bit c, input bit z, input bit b);
        bit [7:0] table_v;
        table_v = {c | z, ~b, b, ~z, z, ~c, c, 1'b1};
        return table_v[sel];
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_stk.delete();
        m_rv  = 3'b000;
        m_ovf = 1'b0; m_unf = 1'b0;
        m_pa  = 1'b0; m_qa  = 1'b0;
        m_ca  = 1'b0; m_ct  = 1'b0;
    endtask

    // Applies the effect of the clock edge that just occurred, using the
    // inputs that were held across it.
    task automatic model_edge();
        if (!rst_n) return;
        m_ca = cond_req;
        m_ct = cond_req ? cond_ref(cond_sel, flag_c, flag_z, flag_b) : 1'b0;
        m_pa = 1'b0;
        m_qa = 1'b0;
        if (m_phase != 0) begin
            m_phase = 0;
        end else if (clr_req) begin
            m_phase = 1;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (pop_req) begin
            m_qa = 1'b1;
            if (m_stk.size() > 0) begin
                m_rv = m_stk.pop_back();
                m_phase = 2;
            end else begin
                m_unf = 1'b1;
            end
        end else if (push_req) begin
            m_pa = 1'b1;
            if (m_stk.size() < DEPTH) m_stk.push_back({flag_c, flag_z, flag_b});
            else m_ovf = 1'b1;
        end
    endtask

    function automatic logic [OW-1:0] model_obs();
        logic [OW-1:0] e;
        e = '0;
        e[CW-1:0] = CW'(m_stk.size());
        e[B_UNF] = m_unf;
        e[B_OVF] = m_ovf;
        e[B_CT]  = m_ct;
        e[B_CA]  = m_ca;
        e[B_QA]  = m_qa;
        e[B_PA]  = m_pa;
        if (m_phase == 1) begin
            e[B_RST] = 1'b1;
            e[B_BSY] = 1'b1;
        end else if (m_phase == 2) begin
            e[B_BSY] = 1'b1;
            e[B_CBV] = 1'b1;
            {e[B_CIN], e[B_ZIN], e[B_BIN]} = m_rv;
        end else begin
            e[B_CBV] = alu_valid & alu_cb & rst_n;
            e[B_CIN] = alu_c;
            e[B_ZIN] = alu_valid ? alu_z : flag_z;
            e[B_BIN] = alu_b;
        end
        return e;
    endfunction

    function automatic logic [OW-1:0] dut_obs();
        return {flag_rst, flag_cb_valid, flag_c_in, flag_z_in, flag_b_in,
                busy, push_ack, pop_ack, cond_ack, cond_true,
                stk_ovf, stk_unf, stk_cnt};
    endfunction

    // ---------------- literal pins (-1 = don't care) ----------------
    bit    pin_on = 1'b0;
    string pin_tag = "";
    int p_rst, p_cbv, p_cin, p_zin, p_bin, p_busy, p_pa, p_qa, p_ca, p_ct, p_ovf, p_unf, p_cnt;

    task automatic pin_clear();
        pin_on = 1'b0;
        p_rst = -1; p_cbv = -1; p_cin = -1; p_zin = -1; p_bin = -1; p_busy = -1;
        p_pa = -1; p_qa = -1; p_ca = -1; p_ct = -1; p_ovf = -1; p_unf = -1; p_cnt = -1;
    endtask

    logic [OW-1:0] c_act, c_exp, c_msk, c_pv;

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (run) begin
            c_act = dut_obs();
            c_exp = model_obs();
            checks++;
            if (c_act !== c_exp) begin
                errors++;
                $display("FAIL model t=%0t got=%h expected=%h", $time, c_act, c_exp);
            end
            if (pin_on) begin
                c_msk = '0;
                c_pv  = '0;
                if (p_rst  >= 0) begin c_msk[B_RST] = 1'b1; c_pv[B_RST] = p_rst[0];  end
                if (p_cbv  >= 0) begin c_msk[B_CBV] = 1'b1; c_pv[B_CBV] = p_cbv[0];  end
                if (p_cin  >= 0) begin c_msk[B_CIN] = 1'b1; c_pv[B_CIN] = p_cin[0];  end
                if (p_zin  >= 0) begin c_msk[B_ZIN] = 1'b1; c_pv[B_ZIN] = p_zin[0];  end
                if (p_bin  >= 0) begin c_msk[B_BIN] = 1'b1; c_pv[B_BIN] = p_bin[0];  end
                if (p_busy >= 0) begin c_msk[B_BSY] = 1'b1; c_pv[B_BSY] = p_busy[0]; end
                if (p_pa   >= 0) begin c_msk[B_PA]  = 1'b1; c_pv[B_PA]  = p_pa[0];   end
                if (p_qa   >= 0) begin c_msk[B_QA]  = 1'b1; c_pv[B_QA]  = p_qa[0];   end
                if (p_ca   >= 0) begin c_msk[B_CA]  = 1'b1; c_pv[B_CA]  = p_ca[0];   end
                if (p_ct   >= 0) begin c_msk[B_CT]  = 1'b1; c_pv[B_CT]  = p_ct[0];   end
                if (p_ovf  >= 0) begin c_msk[B_OVF] = 1'b1; c_pv[B_OVF] = p_ovf[0];  end
                if (p_unf  >= 0) begin c_msk[B_UNF] = 1'b1; c_pv[B_UNF] = p_unf[0];  end
                if (p_cnt  >= 0) begin c_msk[CW-1:0] = '1;  c_pv[CW-1:0] = p_cnt[CW-1:0]; end
                checks++;
                if ((c_act & c_msk) !== (c_pv & c_msk)) begin
                    errors++;
                    $display("FAIL %s t=%0t got=%h expected=%h mask=%h",
                             pin_tag, $time, c_act & c_msk, c_pv & c_msk, c_msk);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic step();
        tick();
        pin_clear();
    endtask

    task automatic drive_idle();
        alu_valid = 1'b0; alu_cb = 1'b0; alu_c = 1'b0; alu_z = 1'b0; alu_b = 1'b0;
        flag_c = 1'b0; flag_z = 1'b0; flag_b = 1'b0;
        clr_req = 1'b0; push_req = 1'b0; pop_req = 1'b0; cond_req = 1'b0; cond_sel = 3'd0;
    endtask

    task automatic drive_random();
        alu_valid = 1'($urandom_range(0, 1));
        alu_cb    = 1'($urandom_range(0, 1));
        alu_c     = 1'($urandom_range(0, 1));
        alu_z     = 1'($urandom_range(0, 1));
        alu_b     = 1'($urandom_range(0, 1));
        flag_c    = 1'($urandom_range(0, 1));
        flag_z    = 1'($urandom_range(0, 1));
        flag_b    = 1'($urandom_range(0, 1));
        clr_req   = ($urandom_range(0, 99) < 8);
        pop_req   = ($urandom_range(0, 99) < 25);
        push_req  = ($urandom_range(0, 99) < 35);
        cond_req  = ($urandom_range(0, 99) < 40);
        cond_sel  = 3'($urandom_range(0, 7));
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        pin_clear();
        run = 1'b1;

        // reset state, with ALU strobes active while reset is held
        alu_valid = 1'b1; alu_cb = 1'b1;
        pin_tag = "reset_state";
        p_rst = 0; p_cbv = 0; p_busy = 0; p_pa = 0; p_qa = 0; p_ca = 0; p_ct = 0;
        p_ovf = 0; p_unf = 0; p_cnt = 0; pin_on = 1'b1;
        step();
        alu_valid = 1'b0; alu_cb = 1'b0;
        #1 rst_n = 1'b1;

        // save/restore round trip
        step();
        flag_c = 1'b1; flag_z = 1'b0; flag_b = 1'b1; push_req = 1'b1;
        step();
        push_req = 1'b0;
        pin_tag = "push_ack_cnt1"; p_pa = 1; p_cnt = 1; p_busy = 0; pin_on = 1'b1;
        flag_c = 1'b0; flag_z = 1'b1; flag_b = 1'b0; pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        pin_tag = "restore_cycle";
        p_cin = 1; p_zin = 0; p_bin = 1; p_cbv = 1; p_rst = 0; p_qa = 1; p_cnt = 0; p_busy = 1;
        pin_on = 1'b1;

        // underflow
        step();
        pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        pin_tag = "underflow"; p_qa = 1; p_unf = 1; p_busy = 0; p_cbv = 0; p_cnt = 0; pin_on = 1'b1;

        // five pushes into a four-deep stack
        push_req = 1'b1; flag_c = 1'b1; flag_z = 1'b1; flag_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            flag_b = ~flag_b;
        end
        step();
        push_req = 1'b0;
        pin_tag = "overflow"; p_pa = 1; p_ovf = 1; p_cnt = 4; pin_on = 1'b1;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        pin_tag = "clear_cycle"; p_rst = 1; p_cbv = 0; p_ovf = 0; p_unf = 0; p_cnt = 4; p_busy = 1;
        p_cin = 0; p_zin = 0; p_bin = 0; pin_on = 1'b1;

        // two pops to reach occupancy 2, then all three requests at once
        for (int k = 0; k < 2; k++) begin
            step();
            pop_req = 1'b1;
            step();
            pop_req = 1'b0;
        end
        step();
        clr_req = 1'b1; pop_req = 1'b1; push_req = 1'b1;
        pin_tag = "pre_triple"; p_cnt = 2; p_busy = 0; pin_on = 1'b1;
        step();
        clr_req = 1'b0; pop_req = 1'b0; push_req = 1'b0;
        pin_tag = "triple_clear"; p_rst = 1; p_busy = 1; p_cnt = 2; p_pa = 0; p_qa = 0; pin_on = 1'b1;
        step();
        pin_tag = "triple_after"; p_rst = 0; p_busy = 0; p_cnt = 2; p_pa = 0; p_qa = 0; pin_on = 1'b1;

        // condition queries
        flag_c = 1'b0; flag_z = 1'b1; cond_req = 1'b1; cond_sel = 3'd7;
        step();
        pin_tag = "cond_sel7"; p_ca = 1; p_ct = 1; pin_on = 1'b1;
        flag_c = 1'b1; cond_sel = 3'd2;
        step();
        pin_tag = "cond_sel2"; p_ca = 1; p_ct = 0; pin_on = 1'b1;
        cond_req = 1'b0;

        // reset during RESTORE
        pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        pin_tag = "restore_before_rst"; p_busy = 1; p_qa = 1; p_cnt = 1; pin_on = 1'b1;
        #1;
        rst_n = 1'b0;
        model_reset();
        alu_valid = 1'b1; alu_cb = 1'b1;
        pin_tag = "async_reset"; p_qa = 0; p_cnt = 0; p_busy = 0; p_cbv = 0; p_rst = 0;
        p_ovf = 0; p_unf = 0; p_ca = 0; p_ct = 0;
        step();
        alu_valid = 1'b0; alu_cb = 1'b0;
        #1 rst_n = 1'b1;
        step();
        pin_tag = "after_release"; p_cnt = 0; p_busy = 0; p_qa = 0; pin_on = 1'b1;

        // randomized traffic with occasional mid-cycle resets
        for (int n = 0; n < 3000; n++) begin
            step();
            if (!rst_n) begin
                #1 rst_n = 1'b1;
            end
            drive_random();
            if ($urandom_range(0, 249) == 0) begin
                #1;
                rst_n = 1'b0;
                model_reset();
            end
        end

        step();
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
